calendario_semanal: RTL and testbench
=====================================

Name: calendario_semanal

Overview:
- Sequential day-of-week tracker: holds the current day code and advances it on a one-cycle day tick.
- Decodes the same day flags the team's weekday decoder produces: p (even code: terça/quinta/sábado) and dom (domingo). Adds a weekend flag, a parametrised week counter, a programmable day alarm and a load path with illegal-code rejection.
- Sits between the day-tick generator and the display/control logic.

Parameters:
- WEEK_W, 6, width of the week counter; wraps modulo 2^WEEK_W.
- FIRST_DAY, 3'b001, day code loaded on reset. Must be 1..7; 000 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- adv  input  1  day tick, one-cycle pulse; advances one day.
- ld  input  1  load request.
- ld_day  input  3  day code to load; 001=segunda … 111=domingo.
- alm_en  input  1  alarm enable.
- alm_day  input  3  alarm day code.
- day  output  3  current day code (registered).
- p  output  1  1 when day[0]==0 (terça, quinta, sábado).
- dom  output  1  1 when day==3'b111.
- fds  output  1  1 when day is 110 or 111.
- week_cnt  output  WEEK_W  completed weeks, counted at each domingo->segunda step.
- week_wrap  output  1  one-cycle pulse when week_cnt wraps to 0.
- alm  output  1  one-cycle pulse on arrival at alm_day.
- ld_err  output  1  one-cycle pulse when a load with code 000 is rejected.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - day=FIRST_DAY, week_cnt=0.
  - week_wrap=0, alm=0, ld_err=0.
  - rst overrides ld and adv in the same cycle.
- Flags p, dom, fds are combinational decodes of the day register, so they are valid in the same cycle as day. Their reset values follow FIRST_DAY; with the default: p=0, dom=0, fds=0.
- Priority per edge: rst > ld > adv > hold.
- Load (ld=1):
  - If ld_day != 000: day <= ld_day next cycle; week_cnt unchanged; no alm, no week_wrap.
  - If ld_day == 000: day holds; ld_err=1 for exactly one cycle.
  - A concurrent adv is discarded in both cases.
- Advance (adv=1, ld=0):
  - day 001..110: day <= day+1.
  - day 111: day <= 001 and week_cnt <= week_cnt+1.
  - If week_cnt was all-ones: week_cnt <= 0 and week_wrap=1 for one cycle, aligned with the day update.
- Latency: day, week_cnt and all pulses update at the edge after the sampled adv/ld. Exactly one step per adv-high cycle, so back-to-back adv gives one day per cycle.
- Alarm: alm=1 in the cycle after an advance whose new day equals alm_day, only if alm_en=1 at the adv edge. Never raised by load or reset. alm_day=000 never matches.
- Pulse outputs (alm, ld_err, week_wrap) are registered and deassert the following cycle unless re-triggered.
- Illegal day 000 cannot be reached: reset uses a legal FIRST_DAY and loads reject 000.

Decomposition:
- Shared package holds:
  - day code constants SEG=001, TER=010, QUA=011, QUI=100, SEX=101, SAB=110, DOM=111, and DIA_INV=000;
  - the day-code typedef (3-bit);
  - helper function next_day(code).
- One natural sub-module: dia_flags, a combinational decode of day to p/dom/fds. It is reused by the existing weekday logic.
- Counter and alarm stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles -> day=001, week_cnt=0, p=0, dom=0, fds=0, all pulses 0.
- Full week: 7 adv pulses from 001 -> day steps 010..111 then 001. p=1 on 010/100/110, dom=1 only on 111, fds=1 on 110/111, week_cnt=1 after the 7th pulse.
- Week wrap: WEEK_W=2, advance 28 days from 001 -> week_cnt 1,2,3,0; week_wrap high exactly one cycle, at the 4th domingo->segunda step.
- Load: ld=1, ld_day=110 with adv=1 -> day=110 next cycle, adv ignored, week_cnt unchanged. Then ld_day=000 -> day stays 110, ld_err pulses once.
- Alarm: alm_en=1, alm_day=101, advance from 011 -> alm high only in the cycle day becomes 101. Loading 101 directly -> no alm. alm_en=0 -> no alm.
- Reset mid-operation: rst=1 together with ld=1 and adv=1 while day=111 and week_cnt=3 -> day=001, week_cnt=0, no week_wrap.

Source files
------------

// File: rtl/calendario_semanal_pkg.sv
// Day-of-week codes and helpers shared by the weekly calendar and the weekday decoder.
package calendario_semanal_pkg;

  typedef logic [2:0] dia_t;

  localparam dia_t DIA_INV = 3'b000;
  localparam dia_t SEG     = 3'b001;
  localparam dia_t TER     = 3'b010;
  localparam dia_t QUA     = 3'b011;
  localparam dia_t QUI     = 3'b100;
  localparam dia_t SEX     = 3'b101;
  localparam dia_t SAB     = 3'b110;
  localparam dia_t DOM     = 3'b111;

  // Domingo rolls over to segunda; 000 is never produced.
  function automatic dia_t next_day(input dia_t code);
    next_day = (code == DOM) ? SEG : dia_t'(code + 3'd1);
  endfunction

endpackage

// File: rtl/calendario_semanal_dia_flags.sv
// Combinational decode of a day code into the even-day, domingo and weekend flags.
module dia_flags
  import calendario_semanal_pkg::*;
(
  input  logic [2:0] day_i,
  output logic       p_o,
  output logic       dom_o,
  output logic       fds_o
);

  assign p_o   = ~day_i[0];
  assign dom_o = (day_i == DOM);
  assign fds_o = (day_i == SAB) || (day_i == DOM);

endmodule

// File: rtl/calendario_semanal.sv
// Weekly day tracker: day register, week counter with wrap pulse, day alarm and checked load.
module calendario_semanal
  import calendario_semanal_pkg::*;
#(
  parameter int         WEEK_W    = 6,
  parameter logic [2:0] FIRST_DAY = 3'b001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              ld,
  input  logic [2:0]        ld_day,
  input  logic              alm_en,
  input  logic [2:0]        alm_day,
  output logic [2:0]        day,
  output logic              p,
  output logic              dom,
  output logic              fds,
  output logic [WEEK_W-1:0] week_cnt,
  output logic              week_wrap,
  output logic              alm,
  output logic              ld_err
);

  dia_t              day_q, day_d;
  logic [WEEK_W-1:0] week_q, week_d;
  logic              wrap_q, wrap_d;
  logic              alm_q, alm_d;
  logic              lderr_q, lderr_d;
  dia_t              nxt;

  assign nxt = next_day(day_q);

  // Load wins over advance; a rejected load only raises ld_err.
  always_comb begin
    day_d   = day_q;
    week_d  = week_q;
    wrap_d  = 1'b0;
    alm_d   = 1'b0;
    lderr_d = 1'b0;
    if (ld) begin
      if (ld_day != DIA_INV) day_d = ld_day;
      else                   lderr_d = 1'b1;
    end else if (adv) begin
      day_d = nxt;
      alm_d = alm_en && (alm_day != DIA_INV) && (nxt == alm_day);
      if (day_q == DOM) begin
        week_d = week_q + 1'b1;
        wrap_d = &week_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= FIRST_DAY;
      week_q  <= '0;
      wrap_q  <= 1'b0;
      alm_q   <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      week_q  <= week_d;
      wrap_q  <= wrap_d;
      alm_q   <= alm_d;
      lderr_q <= lderr_d;
    end
  end

  dia_flags u_flags (
    .day_i (day_q),
    .p_o   (p),
    .dom_o (dom),
    .fds_o (fds)
  );

  assign day       = day_q;
  assign week_cnt  = week_q;
  assign week_wrap = wrap_q;
  assign alm       = alm_q;
  assign ld_err    = lderr_q;

endmodule

// File: tb/tb_calendario_semanal.sv
// Directed bench for the weekly calendar, built with a 2-bit week counter so wraps are quick.
module tb_calendario_semanal;

  logic       clk = 1'b0;
  logic       rst, adv, ld, alm_en;
  logic [2:0] ld_day, alm_day;
  logic [2:0] day;
  logic       p, dom, fds, week_wrap, alm, ld_err;
  logic [1:0] week_cnt;

  int checks   = 0;
  int failures = 0;

  calendario_semanal #(.WEEK_W(2), .FIRST_DAY(3'b001)) dut (
    .clk(clk), .rst(rst), .adv(adv), .ld(ld), .ld_day(ld_day),
    .alm_en(alm_en), .alm_day(alm_day), .day(day), .p(p), .dom(dom),
    .fds(fds), .week_cnt(week_cnt), .week_wrap(week_wrap), .alm(alm),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  // Hand-computed sequence for 7 advances starting at segunda.
  logic [2:0] exp_day [7] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
  logic       exp_p   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       exp_dom [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       exp_fds [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; adv = 0; ld = 0; ld_day = 3'b000; alm_en = 0; alm_day = 3'b000;
    step(); step();
    rst = 0;
    checks++; if (day !== 3'b001) begin failures++; $display("FAIL reset_day got=%b exp=001", day); end
    checks++; if (week_cnt !== 2'd0) begin failures++; $display("FAIL reset_week got=%0d exp=0", week_cnt); end
    checks++; if ({p, dom, fds} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {p, dom, fds}); end
    checks++; if ({week_wrap, alm, ld_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {week_wrap, alm, ld_err}); end
  endtask

  task automatic test_full_week();
    adv = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (day !== exp_day[i]) begin failures++; $display("FAIL week_day[%0d] got=%b exp=%b", i, day, exp_day[i]); end
      checks++; if ({p, dom, fds} !== {exp_p[i], exp_dom[i], exp_fds[i]}) begin
        failures++; $display("FAIL week_flags[%0d] got=%b exp=%b", i, {p, dom, fds}, {exp_p[i], exp_dom[i], exp_fds[i]});
      end
    end
    adv = 0;
    checks++; if (week_cnt !== 2'd1) begin failures++; $display("FAIL week_cnt_after7 got=%0d exp=1", week_cnt); end
    checks++; if (week_wrap !== 1'b0) begin failures++; $display("FAIL week_nowrap got=%b exp=0", week_wrap); end
  endtask

  task automatic test_week_wrap();
    rst = 1; step(); rst = 0;
    adv = 1;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k % 7 == 0) begin
        checks++; if (week_cnt !== 2'((k / 7) % 4)) begin
          failures++; $display("FAIL wrap_week[%0d] got=%0d exp=%0d", k, week_cnt, (k / 7) % 4);
        end
      end
      checks++; if (week_wrap !== (k == 28)) begin
        failures++; $display("FAIL wrap_pulse[%0d] got=%b exp=%b", k, week_wrap, (k == 28));
      end
    end
    adv = 0;
    step();
    checks++; if (week_wrap !== 1'b0) begin failures++; $display("FAIL wrap_deassert got=%b exp=0", week_wrap); end
    checks++; if (day !== 3'b001) begin failures++; $display("FAIL wrap_day got=%b exp=001", day); end
  endtask

  task automatic test_load();
    ld = 1; ld_day = 3'b110; adv = 1;
    step();
    checks++; if (day !== 3'b110) begin failures++; $display("FAIL load_day got=%b exp=110", day); end
    checks++; if (week_cnt !== 2'd0) begin failures++; $display("FAIL load_week got=%0d exp=0", week_cnt); end
    checks++; if ({week_wrap, alm, ld_err} !== 3'b000) begin failures++; $display("FAIL load_pulses got=%b exp=000", {week_wrap, alm, ld_err}); end
    ld_day = 3'b000; adv = 0;
    step();
    checks++; if (day !== 3'b110) begin failures++; $display("FAIL load_inv_day got=%b exp=110", day); end
    checks++; if (ld_err !== 1'b1) begin failures++; $display("FAIL load_err_pulse got=%b exp=1", ld_err); end
    ld = 0;
    step();
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL load_err_clear got=%b exp=0", ld_err); end
    checks++; if (day !== 3'b110) begin failures++; $display("FAIL load_hold got=%b exp=110", day); end
  endtask

  task automatic test_alarm();
    ld = 1; ld_day = 3'b011; step(); ld = 0;
    alm_en = 1; alm_day = 3'b101; adv = 1;
    step();
    checks++; if ({day, alm} !== {3'b100, 1'b0}) begin failures++; $display("FAIL alarm_pre got=%b/%b exp=100/0", day, alm); end
    step();
    checks++; if ({day, alm} !== {3'b101, 1'b1}) begin failures++; $display("FAIL alarm_hit got=%b/%b exp=101/1", day, alm); end
    adv = 0;
    step();
    checks++; if (alm !== 1'b0) begin failures++; $display("FAIL alarm_clear got=%b exp=0", alm); end
    ld = 1; ld_day = 3'b100; step(); ld_day = 3'b101; step(); ld = 0;
    checks++; if ({day, alm} !== {3'b101, 1'b0}) begin failures++; $display("FAIL alarm_on_load got=%b/%b exp=101/0", day, alm); end
    ld = 1; ld_day = 3'b100; step(); ld = 0;
    alm_en = 0; adv = 1;
    step();
    adv = 0;
    checks++; if ({day, alm} !== {3'b101, 1'b0}) begin failures++; $display("FAIL alarm_disabled got=%b/%b exp=101/0", day, alm); end
  endtask

  task automatic test_reset_mid();
    rst = 1; step(); rst = 0;
    adv = 1;
    for (int k = 0; k < 21; k++) step();
    adv = 0;
    ld = 1; ld_day = 3'b111; step(); ld = 0;
    checks++; if ({day, week_cnt} !== {3'b111, 2'd3}) begin failures++; $display("FAIL mid_setup got=%b/%0d exp=111/3", day, week_cnt); end
    alm_en = 1; alm_day = 3'b001;
    rst = 1; ld = 1; ld_day = 3'b010; adv = 1;
    step();
    rst = 0; ld = 0; adv = 0;
    checks++; if ({day, week_cnt} !== {3'b001, 2'd0}) begin failures++; $display("FAIL mid_state got=%b/%0d exp=001/0", day, week_cnt); end
    checks++; if ({week_wrap, alm, ld_err} !== 3'b000) begin failures++; $display("FAIL mid_pulses got=%b exp=000", {week_wrap, alm, ld_err}); end
  endtask

  initial begin
    test_reset();
    test_full_week();
    test_week_wrap();
    test_load();
    test_alarm();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
